// File: rtl/multicycle_seq_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding and reset PC.
package multicycle_seq_pkg;

  localparam int          SEQ_STATE_WIDTH = 3;
  localparam logic [31:0] SEQ_RESET_PC    = 32'h8000_0000;

  typedef enum logic [SEQ_STATE_WIDTH-1:0] {
    SEQ_FETCH    = 3'd0,
    SEQ_IF_WAIT  = 3'd1,
    SEQ_EXEC     = 3'd2,
    SEQ_MEM_REQ  = 3'd3,
    SEQ_MEM_WAIT = 3'd4,
    SEQ_WB       = 3'd5,
    SEQ_HALT     = 3'd6
  } seq_state_e;

endpackage

// File: rtl/multicycle_seq_watchdog.sv
// Handshake watchdog: counts enabled cycles and flags the TIMEOUT-th one.
// TIMEOUT of 0 disables the terminal-count output.
module multicycle_seq_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_tc = (TIMEOUT != 0) && i_en && (cnt == TC_VAL);

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle fetch/execute/memory/writeback sequencer with valid/ready
// handshakes, retire/cycle counters, bus-timeout watchdog and halt.
//
// state        | meaning
// -------------+--------------------------------------------------
// SEQ_FETCH    | fetch request on o_if_addr, waiting for i_if_ready
// SEQ_IF_WAIT  | fetch accepted, waiting for i_if_rvalid
// SEQ_EXEC     | decode/ALU settle, pick next phase
// SEQ_MEM_REQ  | data request valid, waiting for i_mem_ready
// SEQ_MEM_WAIT | data request accepted, waiting for i_mem_rvalid
// SEQ_WB       | regfile write, PC update, retire
// SEQ_HALT     | ebreak or bus timeout; absorbing until reset
module multicycle_seq
  import multicycle_seq_pkg::*;
#(
  parameter int                   CPU_WIDTH = 32,
  parameter int                   INS_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(SEQ_RESET_PC),
  parameter int                   CNT_WIDTH = 64,
  parameter int                   TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CPU_WIDTH-1:0] i_next_pc,
  input  logic                 i_idu_lden,
  input  logic                 i_idu_sten,
  input  logic                 i_idu_rd_wren,
  input  logic                 i_idu_ebreak,
  output logic                 o_if_valid,
  output logic [CPU_WIDTH-1:0] o_if_addr,
  input  logic                 i_if_ready,
  input  logic                 i_if_rvalid,
  input  logic [INS_WIDTH-1:0] i_if_rdata,
  output logic [INS_WIDTH-1:0] o_ir,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic                 o_mem_valid,
  output logic                 o_mem_wr,
  input  logic                 i_mem_ready,
  input  logic                 i_mem_rvalid,
  output logic                 o_rf_we,
  output logic                 o_rf_sel_mem,
  output logic                 o_retire,
  output logic                 o_halt,
  output logic                 o_err,
  output logic [CNT_WIDTH-1:0] o_cycle,
  output logic [CNT_WIDTH-1:0] o_instret
);

  seq_state_e state_q, state_d;

  logic ir_load;
  logic retire_d;
  logic timeout_d;
  logic if_tc, mem_tc;
  logic if_wd_en, mem_wd_en, wd_clr;

  assign if_wd_en  = (state_q == SEQ_FETCH)   || (state_q == SEQ_IF_WAIT);
  assign mem_wd_en = (state_q == SEQ_MEM_REQ) || (state_q == SEQ_MEM_WAIT);
  assign wd_clr    = (state_d != state_q);

  multicycle_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_if_wd (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (wd_clr),
    .i_en  (if_wd_en),
    .o_tc  (if_tc)
  );

  multicycle_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_mem_wd (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (wd_clr),
    .i_en  (mem_wd_en),
    .o_tc  (mem_tc)
  );

  assign o_if_addr = o_pc;

  // A completed handshake wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_d      = state_q;
    o_if_valid   = 1'b0;
    o_mem_valid  = 1'b0;
    o_mem_wr     = 1'b0;
    o_rf_we      = 1'b0;
    o_rf_sel_mem = 1'b0;
    ir_load      = 1'b0;
    retire_d     = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      SEQ_FETCH: begin
        o_if_valid = 1'b1;
        if (i_if_ready && i_if_rvalid) begin
          ir_load = 1'b1;
          state_d = SEQ_EXEC;
        end else if (i_if_ready) begin
          state_d = SEQ_IF_WAIT;
        end else if (if_tc) begin
          timeout_d = 1'b1;
          state_d   = SEQ_HALT;
        end
      end
      SEQ_IF_WAIT: begin
        if (i_if_rvalid) begin
          ir_load = 1'b1;
          state_d = SEQ_EXEC;
        end else if (if_tc) begin
          timeout_d = 1'b1;
          state_d   = SEQ_HALT;
        end
      end
      SEQ_EXEC: begin
        if (i_idu_ebreak) begin
          retire_d = 1'b1;
          state_d  = SEQ_HALT;
        end else if (i_idu_lden || i_idu_sten) begin
          state_d = SEQ_MEM_REQ;
        end else begin
          state_d = SEQ_WB;
        end
      end
      SEQ_MEM_REQ: begin
        o_mem_valid = 1'b1;
        o_mem_wr    = i_idu_sten;
        if (i_mem_ready && i_mem_rvalid) begin
          state_d = SEQ_WB;
        end else if (i_mem_ready) begin
          state_d = SEQ_MEM_WAIT;
        end else if (mem_tc) begin
          timeout_d = 1'b1;
          state_d   = SEQ_HALT;
        end
      end
      SEQ_MEM_WAIT: begin
        if (i_mem_rvalid) begin
          state_d = SEQ_WB;
        end else if (mem_tc) begin
          timeout_d = 1'b1;
          state_d   = SEQ_HALT;
        end
      end
      SEQ_WB: begin
        o_rf_we      = (i_idu_rd_wren | i_idu_lden) & ~i_idu_sten;
        o_rf_sel_mem = i_idu_lden;
        retire_d     = 1'b1;
        state_d      = SEQ_FETCH;
      end
      SEQ_HALT: state_d = SEQ_HALT;
      default:  state_d = SEQ_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= SEQ_FETCH;
      o_pc      <= RESET_PC;
      o_ir      <= '0;
      o_retire  <= 1'b0;
      o_halt    <= 1'b0;
      o_err     <= 1'b0;
      o_cycle   <= '0;
      o_instret <= '0;
    end else begin
      state_q  <= state_d;
      o_retire <= retire_d;
      if (ir_load) begin
        o_ir <= i_if_rdata;
      end
      if (state_q == SEQ_WB) begin
        o_pc <= i_next_pc;
      end
      if (retire_d) begin
        o_instret <= o_instret + CNT_WIDTH'(1);
      end
      if (state_q != SEQ_HALT) begin
        o_cycle <= o_cycle + CNT_WIDTH'(1);
      end
      if (state_d == SEQ_HALT) begin
        o_halt <= 1'b1;
      end
      if (timeout_d) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: expected retire records are queued
// when an instruction is issued and compared when o_retire is observed.
module tb_multicycle_seq;

  localparam int          CW  = 32;
  localparam int          IW  = 32;
  localparam int          NW  = 64;
  localparam int          TO  = 4;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [CW-1:0] i_next_pc = '0;
  logic          i_idu_lden = 1'b0, i_idu_sten = 1'b0, i_idu_rd_wren = 1'b0, i_idu_ebreak = 1'b0;
  logic          o_if_valid;
  logic [CW-1:0] o_if_addr;
  logic          i_if_ready = 1'b0, i_if_rvalid = 1'b0;
  logic [IW-1:0] i_if_rdata = '0;
  logic [IW-1:0] o_ir;
  logic [CW-1:0] o_pc;
  logic          o_mem_valid, o_mem_wr;
  logic          i_mem_ready = 1'b0, i_mem_rvalid = 1'b0;
  logic          o_rf_we, o_rf_sel_mem, o_retire, o_halt, o_err;
  logic [NW-1:0] o_cycle, o_instret;

  multicycle_seq #(
    .CPU_WIDTH(CW), .INS_WIDTH(IW), .RESET_PC(RPC), .CNT_WIDTH(NW), .TIMEOUT(TO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_next_pc(i_next_pc),
    .i_idu_lden(i_idu_lden), .i_idu_sten(i_idu_sten),
    .i_idu_rd_wren(i_idu_rd_wren), .i_idu_ebreak(i_idu_ebreak),
    .o_if_valid(o_if_valid), .o_if_addr(o_if_addr),
    .i_if_ready(i_if_ready), .i_if_rvalid(i_if_rvalid), .i_if_rdata(i_if_rdata),
    .o_ir(o_ir), .o_pc(o_pc),
    .o_mem_valid(o_mem_valid), .o_mem_wr(o_mem_wr),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid),
    .o_rf_we(o_rf_we), .o_rf_sel_mem(o_rf_sel_mem), .o_retire(o_retire),
    .o_halt(o_halt), .o_err(o_err), .o_cycle(o_cycle), .o_instret(o_instret)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] instret;
    logic [63:0] cycle;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ir;
  logic [63:0] exp_instret;
  logic [63:0] exp_cycle;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge i_clk) begin : retire_mon
    exp_t e;
    if (i_rst && o_retire) begin
      if (sb.size() == 0) begin
        check_eq("retire_spurious", {63'd0, o_retire}, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("retire_pc", {32'd0, o_pc}, {32'd0, e.pc});
        check_eq("retire_instret", o_instret, e.instret);
        check_eq("retire_cycle", o_cycle, e.cycle);
      end
    end
  end

  task automatic model_reset();
    exp_pc      = RPC;
    exp_ir      = '0;
    exp_instret = '0;
    exp_cycle   = '0;
  endtask

  // Entered and left at a negedge; the first cycle is a FETCH cycle.
  task automatic run_instr(input string tag, input bit ld, input bit st, input bit rdw,
                           input bit eb, input int if_rdy, input int if_rv,
                           input int mem_rdy, input int mem_rv,
                           input logic [31:0] insn, input logic [31:0] npc);
    exp_t e;
    int   cyc;
    int   mv;
    bit   mem_op;
    mem_op = (ld || st) && !eb;
    cyc = if_rdy + 1 + if_rv + 1 + (mem_op ? (mem_rdy + 1 + mem_rv) : 0) + (eb ? 0 : 1);
    exp_cycle   = exp_cycle + 64'(cyc);
    exp_instret = exp_instret + 64'd1;
    e.pc      = eb ? exp_pc : npc;
    e.instret = exp_instret;
    e.cycle   = exp_cycle;
    sb.push_back(e);
    i_idu_lden = ld; i_idu_sten = st; i_idu_rd_wren = rdw; i_idu_ebreak = eb;
    i_next_pc  = npc;

    for (int k = 0; k <= if_rdy; k++) begin
      check_eq({tag, "_if_valid"}, {63'd0, o_if_valid}, 64'd1);
      check_eq({tag, "_if_addr"}, {32'd0, o_if_addr}, {32'd0, exp_pc});
      i_if_ready  = (k == if_rdy);
      i_if_rvalid = (k == if_rdy) && (if_rv == 0);
      i_if_rdata  = i_if_rvalid ? insn : ~insn;
      @(negedge i_clk);
    end
    i_if_ready = 1'b0;
    for (int k = 1; k <= if_rv; k++) begin
      check_eq({tag, "_ir_hold"}, {32'd0, o_ir}, {32'd0, exp_ir});
      check_eq({tag, "_if_wait_valid"}, {63'd0, o_if_valid}, 64'd0);
      i_if_rvalid = (k == if_rv);
      i_if_rdata  = i_if_rvalid ? insn : ~insn;
      @(negedge i_clk);
    end
    i_if_rvalid = 1'b0;
    i_if_rdata  = '0;
    exp_ir = insn;

    check_eq({tag, "_ir"}, {32'd0, o_ir}, {32'd0, insn});
    check_eq({tag, "_exec_memv"}, {63'd0, o_mem_valid}, 64'd0);
    @(negedge i_clk);
    if (eb) begin
      check_eq({tag, "_halt"}, {63'd0, o_halt}, 64'd1);
      return;
    end

    if (mem_op) begin
      mv = 0;
      for (int k = 0; k <= mem_rdy; k++) begin
        if (o_mem_valid) mv++;
        check_eq({tag, "_mem_wr"}, {63'd0, o_mem_wr}, {63'd0, st});
        i_mem_ready  = (k == mem_rdy);
        i_mem_rvalid = (k == mem_rdy) && (mem_rv == 0);
        @(negedge i_clk);
      end
      i_mem_ready = 1'b0;
      for (int k = 1; k <= mem_rv; k++) begin
        if (o_mem_valid) mv++;
        i_mem_rvalid = (k == mem_rv);
        @(negedge i_clk);
      end
      i_mem_rvalid = 1'b0;
      check_eq({tag, "_memv_cycles"}, 64'(mv), 64'(mem_rdy + 1));
    end

    check_eq({tag, "_rf_we"}, {63'd0, o_rf_we}, {63'd0, (rdw | ld) & ~st});
    check_eq({tag, "_rf_sel_mem"}, {63'd0, o_rf_sel_mem}, {63'd0, ld});
    check_eq({tag, "_wb_memv"}, {63'd0, o_mem_valid}, 64'd0);
    @(negedge i_clk);
    exp_pc = npc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge i_clk);
    check_eq("rst_pc", {32'd0, o_pc}, {32'd0, RPC});
    check_eq("rst_ir", {32'd0, o_ir}, 64'd0);
    check_eq("rst_cycle", o_cycle, 64'd0);
    check_eq("rst_instret", o_instret, 64'd0);
    check_eq("rst_halt", {63'd0, o_halt}, 64'd0);
    check_eq("rst_err", {63'd0, o_err}, 64'd0);
    check_eq("rst_retire", {63'd0, o_retire}, 64'd0);
    check_eq("rst_rf_we", {63'd0, o_rf_we}, 64'd0);
    i_rst = 1'b1;

    run_instr("alu0", 0, 0, 1, 0, 0, 0, 0, 0, 32'h0010_0093, 32'h8000_0004);
    run_instr("alu1", 0, 0, 1, 0, 0, 0, 0, 0, 32'h0020_0113, 32'h8000_0008);
    run_instr("alu2", 0, 0, 1, 0, 0, 0, 0, 0, 32'h0030_0193, 32'h8000_0010);
    check_eq("instret_after_3", o_instret, 64'd3);
    run_instr("slow_if", 0, 0, 1, 0, 2, 3, 0, 0, 32'h0040_0213, 32'h8000_0014);
    run_instr("load", 1, 0, 1, 0, 0, 0, 0, 2, 32'h0000_a283, 32'h8000_0018);
    run_instr("store", 0, 1, 1, 0, 0, 0, 1, 1, 32'h0050_a023, 32'h8000_001c);
    run_instr("ld_st", 1, 1, 0, 0, 0, 0, 0, 0, 32'h0060_a023, 32'h8000_0020);
    run_instr("ebreak", 0, 0, 0, 1, 1, 0, 0, 0, 32'h0010_0073, 32'hdead_beec);

    i_if_ready = 1'b1; i_if_rvalid = 1'b1; i_mem_ready = 1'b1; i_mem_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      check_eq("halt_cycle_frozen", o_cycle, exp_cycle);
      check_eq("halt_instret", o_instret, exp_instret);
      check_eq("halt_if_valid", {63'd0, o_if_valid}, 64'd0);
      check_eq("halt_mem_valid", {63'd0, o_mem_valid}, 64'd0);
      check_eq("halt_pc", {32'd0, o_pc}, {32'd0, exp_pc});
    end
    i_if_ready = 1'b0; i_if_rvalid = 1'b0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    i_idu_ebreak = 1'b0;

    i_rst = 1'b0;
    @(negedge i_clk);
    check_eq("rst2_halt", {63'd0, o_halt}, 64'd0);
    i_rst = 1'b1;
    model_reset();
    run_instr("post_rst", 0, 0, 1, 0, 0, 0, 0, 0, 32'h0070_0393, 32'h8000_0004);

    i_if_ready = 1'b1;
    @(negedge i_clk);
    i_if_ready = 1'b0;
    #2 i_rst = 1'b0;
    #1;
    check_eq("async_rst_pc", {32'd0, o_pc}, {32'd0, RPC});
    check_eq("async_rst_ir", {32'd0, o_ir}, 64'd0);
    check_eq("async_rst_instret", o_instret, 64'd0);
    check_eq("async_rst_cycle", o_cycle, 64'd0);
    check_eq("async_rst_retire", {63'd0, o_retire}, 64'd0);
    check_eq("async_rst_if_valid", {63'd0, o_if_valid}, 64'd1);
    check_eq("async_rst_if_addr", {32'd0, o_if_addr}, {32'd0, RPC});
    @(negedge i_clk);
    i_rst = 1'b1;
    model_reset();
    run_instr("restart", 0, 0, 1, 0, 0, 0, 0, 0, 32'h0080_0413, 32'h8000_0008);

    i_mem_rvalid = 1'b1;
    for (int k = 0; k < TO; k++) begin
      check_eq("to_err_early", {63'd0, o_err}, 64'd0);
      check_eq("to_halt_early", {63'd0, o_halt}, 64'd0);
      @(negedge i_clk);
    end
    i_mem_rvalid = 1'b0;
    exp_cycle = exp_cycle + 64'(TO);
    check_eq("to_err", {63'd0, o_err}, 64'd1);
    check_eq("to_halt", {63'd0, o_halt}, 64'd1);
    check_eq("to_instret", o_instret, exp_instret);
    check_eq("to_cycle", o_cycle, exp_cycle);
    repeat (3) @(negedge i_clk);
    check_eq("to_cycle_frozen", o_cycle, exp_cycle);
    check_eq("to_err_sticky", {63'd0, o_err}, 64'd1);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Multi-cycle sequencer for the RV32E NPC core; successor to the current single-cycle top-level sequencing.
- Replaces the implicit one-instruction-per-cycle flow with an explicit FSM: fetch, execute, memory and writeback.
- Fetch and data memory use valid/ready handshakes, so variable-latency memories and buses are supported.
- Drives write enables for the PC, IR and regfile, and keeps cycle/instret counters, a bus-timeout watchdog and a halt state.

Parameters:
- CPU_WIDTH, 32, data/address width.
- INS_WIDTH, 32, instruction width.
- RESET_PC, 32'h80000000, first fetch address.
- CNT_WIDTH, 64, width of the cycle and instret counters.
- TIMEOUT, 255, maximum wait cycles per handshake before error; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-low (asserted at 0).
- i_next_pc  in  CPU_WIDTH  next PC from bru.
- i_idu_lden  in  1  decoded load.
- i_idu_sten  in  1  decoded store.
- i_idu_rd_wren  in  1  decoded regfile write.
- i_idu_ebreak  in  1  decoded ebreak.
- o_if_valid  out  1  fetch request valid.
- o_if_addr  out  CPU_WIDTH  fetch address (current PC).
- i_if_ready  in  1  fetch request accepted.
- i_if_rvalid  in  1  fetch response valid.
- i_if_rdata  in  INS_WIDTH  fetched instruction.
- o_ir  out  INS_WIDTH  latched instruction register.
- o_pc  out  CPU_WIDTH  architectural PC.
- o_mem_valid  out  1  data request valid.
- o_mem_wr  out  1  1 = store, 0 = load.
- i_mem_ready  in  1  data request accepted.
- i_mem_rvalid  in  1  data response or store acknowledge.
- o_rf_we  out  1  regfile write strobe.
- o_rf_sel_mem  out  1  writeback source is load data.
- o_retire  out  1  one-cycle instruction-retired pulse.
- o_halt  out  1  sequencer halted.
- o_err  out  1  bus timeout occurred.
- o_cycle  out  CNT_WIDTH  cycle counter.
- o_instret  out  CNT_WIDTH  retired instruction counter.

Behaviour:
- FSM states: FETCH, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- Reset (i_rst=0, asynchronous):
  - state=FETCH, o_pc=RESET_PC, o_ir=0.
  - Counters and watchdog = 0; all strobes, o_halt and o_err = 0.
  - Reset asserted mid-transaction abandons it immediately; no retire.
- FETCH:
  - o_if_valid=1, o_if_addr=o_pc, held stable until i_if_ready.
  - On i_if_ready go to IF_WAIT.
  - If i_if_ready and i_if_rvalid are both 1 in the same cycle, latch o_ir=i_if_rdata and go directly to EXEC (zero-wait memory).
- IF_WAIT: on i_if_rvalid latch o_ir and go to EXEC.
- EXEC (exactly 1 cycle; decode and ALU settle):
  - ebreak goes to HALT.
  - Load or store goes to MEM_REQ.
  - Otherwise go to WB.
- MEM_REQ:
  - o_mem_valid=1; o_mem_wr=i_idu_sten, with store priority if both load and store are decoded.
  - On i_mem_ready go to MEM_WAIT.
  - Same-cycle i_mem_ready and i_mem_rvalid goes to WB.
- MEM_WAIT: on i_mem_rvalid go to WB.
- WB (1 cycle):
  - o_rf_we = (i_idu_rd_wren | i_idu_lden) & ~i_idu_sten.
  - o_rf_sel_mem = i_idu_lden.
  - o_pc <= i_next_pc; o_retire=1; o_instret++; go to FETCH.
- Latency: minimum 3 cycles per ALU instruction and 4 per load/store with zero-wait memory.
- Watchdog:
  - Counts cycles spent in FETCH, IF_WAIT, MEM_REQ and MEM_WAIT; cleared on every state change.
  - When the count reaches TIMEOUT (and TIMEOUT≠0): o_err=1 (sticky), go to HALT, no retire.
- HALT:
  - Absorbing until reset; o_halt=1; all request and strobe outputs 0.
  - ebreak halt retires the ebreak: o_retire pulses in the transition cycle and o_instret increments.
- Counters:
  - o_cycle increments every cycle out of reset except in HALT.
  - Both counters wrap modulo 2^CNT_WIDTH.
- Any response signal arriving in a state that does not wait for it is ignored.
- All outputs are registered except o_if_valid, o_if_addr, o_mem_valid, o_mem_wr, o_rf_we and o_rf_sel_mem, which are decoded from state.

Decomposition:
- Shared defines file (extend defines.v):
  - state encoding constants SEQ_FETCH..SEQ_HALT, 3 bits;
  - SEQ_STATE_WIDTH;
  - RESET_PC default.
- One sub-module, seq_watchdog: a counter with clear, enable and terminal-count output, parametrised by TIMEOUT. It is reused for both handshake channels.

Test Plan:
- Zero-wait memory (ready=rvalid=1 always), 3 ALU instructions → retire pulses on cycles 3, 6, 9; o_instret=3; o_pc=next_pc values.
- Fetch with ready delayed 2 cycles and rvalid 3 cycles after that → o_if_addr stable at 32'h80000000 throughout; o_ir latched only on the rvalid cycle; retire on cycle 8.
- Load with mem latency 2 → o_mem_valid for exactly 1 cycle, o_mem_wr=0; WB cycle has o_rf_we=1, o_rf_sel_mem=1.
- Store → o_mem_wr=1, o_rf_we=0 in WB; o_pc advances.
- TIMEOUT=4, i_if_ready held 0 → o_err=1 and o_halt=1 after 4 cycles; o_instret unchanged; o_cycle frozen.
- ebreak executed → o_retire pulse then o_halt=1. Assert i_rst=0 mid-IF_WAIT on a later run → all outputs return to reset values asynchronously, and fetch restarts at 32'h80000000.
